// File: rtl/data_sram_responder_if.sv
// SRAM-like data bus between a CPU-side requester and a memory-side responder.
// The requester drives en/we/addr/wdata; the responder returns rdata one
// cycle after an accepted read.
interface data_sram_responder_if;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // CPU side: issues requests, consumes read data.
    modport master (
        output sram_en,
        output sram_we,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    // Memory side: consumes requests, returns read data.
    modport slave (
        input  sram_en,
        input  sram_we,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Behavioural SRAM responder standing in for vendor block RAM during
// simulation and FPGA bring-up. After reset it fills every word with
// INIT_VAL (one word per cycle), then serves byte-enabled reads and writes
// with one-cycle read latency. A sticky error flag and saturating access
// counters are exposed for debug.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    data_sram_responder_if.slave   sram,
    output logic                   busy,
    output logic                   err,
    output logic [31:0]            rd_cnt,
    output logic [31:0]            wr_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // Byte span of the window; one extra bit so 4*DEPTH is representable
    // even when the window covers a large part of the 32-bit space.
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         rd_cnt_q, rd_cnt_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;

    logic [31:0]         mem [DEPTH];

    // Write port into the array, shared by the init pass and normal writes.
    logic [3:0]          mem_we;
    logic [ADDR_W-1:0]   mem_widx;
    logic [31:0]         mem_wdata;

    // Request decode. Addresses below BASE_ADDR wrap to huge offsets and
    // therefore fall out of range through the same unsigned compare.
    logic [31:0]         off;
    logic                in_range;
    logic [ADDR_W-1:0]   req_idx;
    logic                req_read;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Decode the byte address into an in-window flag and a word index.
    always_comb begin
        off      = sram.sram_addr - BASE_ADDR;
        in_range = ({1'b0, off} < SPAN);
        req_idx  = off[ADDR_W+1:2];
        req_read = (sram.sram_we == 4'b0000);
    end

    // Next-state logic: init sequencing, request handling, counters, error.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        mem_we     = 4'b0000;
        mem_widx   = req_idx;
        mem_wdata  = sram.sram_wdata;

        unique case (state_q)
            ST_INIT: begin
                // Init write always proceeds, whatever the bus is doing.
                mem_we     = 4'b1111;
                mem_widx   = init_idx_q;
                mem_wdata  = INIT_VAL;
                init_idx_d = init_idx_q + ADDR_W'(1);
                if (init_idx_q == '1) begin
                    state_d = ST_RUN;
                end
                // Requests during init are dropped and flagged.
                if (sram.sram_en) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end

            ST_RUN: begin
                if (sram.sram_en) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (req_read) begin
                            rdata_d = 32'h0;
                        end
                    end else if (req_read) begin
                        rdata_d  = mem[req_idx];
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end else begin
                        mem_we   = sram.sram_we;
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            rd_cnt_q   <= 32'h0;
            wr_cnt_q   <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Byte-lane writes into the storage array.
    // NOTE: the array has no reset; the init pass clears it instead, which
    // keeps it mappable onto RAM primitives.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    assign busy            = (state_q == ST_INIT);
    assign err             = err_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;
    assign sram.sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder with a small memory (16 words).
// A transaction-level model tracks memory contents, read data, error flag,
// counters and the remaining init cycles; every cycle's outputs are compared
// against it.
module tb_data_sram_responder;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h1c00_0000;
    localparam logic [31:0] INIT   = 32'h5A5A_0F0F;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        busy;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    data_sram_responder_if sram_bus ();

    data_sram_responder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .INIT_VAL (INIT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sram   (sram_bus),
        .busy   (busy),
        .err    (err),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_rd;
    logic [31:0] m_wr;
    int          m_busy_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"},   32'(busy),             32'(m_busy_left != 0));
        check({tag, ".err"},    32'(err),              32'(m_err));
        check({tag, ".rdata"},  sram_bus.sram_rdata,   m_rdata);
        check({tag, ".rd_cnt"}, rd_cnt,                m_rd);
        check({tag, ".wr_cnt"}, wr_cnt,                m_wr);
    endtask

    // The init pass overwrites every word before any request can be served,
    // so the model can treat memory as INIT right away.
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
        m_rdata     = 32'h0;
        m_err       = 1'b0;
        m_rd        = 32'h0;
        m_wr        = 32'h0;
        m_busy_left = DEPTH;
    endtask

    // Effect of one clock edge given the request presented during that cycle.
    task automatic model_edge(input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        int          w;
        if (m_busy_left > 0) begin
            if (en) begin
                m_err   = 1'b1;
                m_rdata = 32'h0;
            end
            m_busy_left--;
        end else if (en) begin
            off = addr - BASE;
            if (off >= 4 * DEPTH) begin
                m_err = 1'b1;
                if (we == 4'b0) m_rdata = 32'h0;
            end else begin
                w = int'(off / 4);
                if (we == 4'b0) begin
                    m_rdata = m_mem[w];
                    if (m_rd != 32'hFFFF_FFFF) m_rd++;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (we[k]) m_mem[w][8*k +: 8] = wdata[8*k +: 8];
                    if (m_wr != 32'hFFFF_FFFF) m_wr++;
                end
            end
        end
    endtask

    // Present a request, advance one edge, then compare against the model.
    task automatic step(input string tag, input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
        sram_bus.sram_en    = en;
        sram_bus.sram_we    = we;
        sram_bus.sram_addr  = addr;
        sram_bus.sram_wdata = wdata;
        @(posedge clk);
        model_edge(en, we, addr, wdata);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once, release away
    // from the clock edge.
    task automatic apply_reset(input string tag);
        sram_bus.sram_en = 1'b0;
        resetn = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    logic [31:0] a;
    logic [3:0]  r_we;
    logic        r_en;
    logic [31:0] held;

    initial begin
        sram_bus.sram_en    = 1'b0;
        sram_bus.sram_we    = 4'h0;
        sram_bus.sram_addr  = 32'h0;
        sram_bus.sram_wdata = 32'h0;
        model_reset();

        // Reset values and a clean init pass: busy for exactly DEPTH edges.
        #7;
        apply_reset("reset");
        for (int i = 0; i < DEPTH; i++) idle($sformatf("init%0d", i));
        check("init_done.busy", 32'(busy), 32'h0);

        // Read every word back: each returns INIT one cycle after the read.
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("rd_init%0d", i), 1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
        check("rd_init.value", sram_bus.sram_rdata, INIT);
        check("rd_init.count", rd_cnt, 32'd16);

        // Write then immediate read of the same word.
        apply_reset("reset2");
        for (int i = 0; i < DEPTH; i++) idle($sformatf("init2_%0d", i));
        step("wr_dead", 1'b1, 4'hF, 32'h1c00_0008, 32'hDEADBEEF);
        step("rd_dead", 1'b1, 4'h0, 32'h1c00_0008, 32'h0);
        check("rd_dead.value", sram_bus.sram_rdata, 32'hDEADBEEF);
        check("rd_dead.wr_cnt", wr_cnt, 32'd1);
        check("rd_dead.rd_cnt", rd_cnt, 32'd1);

        // Single byte lane merge over an existing word.
        step("wr_base", 1'b1, 4'hF, 32'h1c00_0010, 32'h11223344);
        step("wr_lane", 1'b1, 4'b0100, 32'h1c00_0010, 32'h00AA_0000);
        step("rd_lane", 1'b1, 4'h0, 32'h1c00_0013, 32'h0);
        check("rd_lane.value", sram_bus.sram_rdata, 32'h11AA3344);

        // en=0 holds the last read data.
        held = sram_bus.sram_rdata;
        idle("hold0");
        idle("hold1");
        check("hold.value", sram_bus.sram_rdata, held);
        check("hold.err", 32'(err), 32'h0);

        // Out-of-range: below base and one past the top; write leaves rdata.
        step("oor_lo", 1'b1, 4'h0, 32'h1bff_fffc, 32'h0);
        check("oor_lo.value", sram_bus.sram_rdata, 32'h0);
        check("oor_lo.err", 32'(err), 32'h1);
        step("rd_ok", 1'b1, 4'h0, 32'h1c00_0008, 32'h0);
        step("oor_wr", 1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'h0BAD_0BAD);
        check("oor_wr.rdata_held", sram_bus.sram_rdata, 32'hDEADBEEF);
        step("oor_hi", 1'b1, 4'h0, BASE + 32'(4 * DEPTH), 32'h0);
        check("oor_hi.value", sram_bus.sram_rdata, 32'h0);
        check("oor.rd_cnt", rd_cnt, 32'd3);
        check("oor.wr_cnt", wr_cnt, 32'd3);
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("rd_after_oor%0d", i), 1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);

        // Request during init at cycle 3, then reset again at cycle 5.
        apply_reset("reset3");
        idle("busy_c0");
        idle("busy_c1");
        idle("busy_c2");
        step("busy_req", 1'b1, 4'hF, BASE, 32'hFFFF_FFFF);
        check("busy_req.err", 32'(err), 32'h1);
        idle("busy_c4");
        apply_reset("reset_mid");
        for (int i = 0; i < DEPTH; i++) idle($sformatf("init4_%0d", i));

        // Request during init: dropped, init still ends on time.
        apply_reset("reset5");
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) step("busy_req2", 1'b1, 4'h0, BASE + 32'd4, 32'h0);
            else        idle($sformatf("init5_%0d", i));
        end
        check("busy_req2.busy_done", 32'(busy), 32'h0);
        step("busy_req2.dropped", 1'b1, 4'h0, BASE, 32'h0);
        check("busy_req2.mem", sram_bus.sram_rdata, INIT);

        // Randomized traffic around the window, including out-of-range hits.
        apply_reset("reset6");
        for (int i = 0; i < DEPTH; i++) idle($sformatf("init6_%0d", i));
        for (int i = 0; i < 400; i++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            a    = BASE - 32'd8 + 32'(4 * $urandom_range(0, DEPTH + 3))
                   + 32'($urandom_range(0, 3));
            step($sformatf("rand%0d", i), r_en, r_we, a, $urandom);
        end
        for (int i = 0; i < DEPTH; i++)
            step($sformatf("final_rd%0d", i), 1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU's SRAM-like data (or instruction) interface: accepts en/we/addr/wdata and returns rdata exactly one cycle after a read.
- Sits outside the CPU top in the SoC and replaces the vendor block RAM for simulation and FPGA bring-up.
- After reset it runs a self-clearing init pass, then serves byte-enabled accesses.
- Provides a sticky error flag and saturating access counters for debug.

Parameters:
- ADDR_W, 12, word-index width; DEPTH = 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h1c00_0000, byte address mapped to word 0.
- INIT_VAL, 32'h0000_0000, value written to every word during the init pass.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- sram_en  in  1  request valid this cycle.
- sram_we  in  4  byte write enables; 4'b0000 with sram_en=1 means read.
- sram_addr  in  32  byte address; bits [1:0] ignored for indexing.
- sram_wdata  in  32  write data, lane-aligned (byte k on bits 8k+7:8k).
- sram_rdata  out  32  read data, valid the cycle after a read request.
- busy  out  1  high while the init pass runs.
- err  out  1  sticky: set by an out-of-range access or any request while busy.
- rd_cnt  out  32  accepted reads, saturating.
- wr_cnt  out  32  accepted writes, saturating.

Behaviour:
- Reset (resetn=0, asynchronous)
  - sram_rdata=0, busy=1, err=0, rd_cnt=0, wr_cnt=0.
  - FSM=INIT, init_idx=0.
  - Memory contents are not reset asynchronously.
- FSM
  - INIT: each cycle writes INIT_VAL to mem[init_idx] and increments init_idx. When init_idx==DEPTH-1 is written, go to RUN the next edge. busy=1 throughout INIT and drops on entry to RUN.
  - Init therefore takes exactly DEPTH cycles after resetn deasserts.
  - RUN: serve requests. No exit except reset.
  - Reset asserted mid-init restarts INIT from index 0.
- Address decode
  - off = sram_addr - BASE_ADDR (32-bit wrap subtraction).
  - In range iff off < 4*DEPTH, treated as unsigned; addresses below BASE wrap high and are therefore out of range.
  - idx = off[ADDR_W+1:2].
- Read (RUN, en=1, we=0, in range)
  - sram_rdata <= mem[idx] at the next edge; rd_cnt++.
- Write (RUN, en=1, we!=0, in range)
  - For each k with we[k]=1: mem[idx] byte k <= wdata byte k; other bytes are unchanged.
  - wr_cnt++. sram_rdata holds its value.
- en=0: no memory change; sram_rdata holds its last value.
- Out-of-range request in RUN
  - No memory change and no counter change; err <= 1.
  - A read sets sram_rdata <= 32'h0; a write leaves sram_rdata held.
- Any request while busy (INIT)
  - Ignored: no memory change, no counter change. err <= 1; sram_rdata <= 0.
  - The init write proceeds unaffected.
- Back-to-back timing
  - Write to A at cycle t, read A at t+1: the read returns the new data at t+2. The write is complete at the edge ending t.
  - No read-after-write hazard inside the block.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- err clears only on reset.

Test Plan:
- Reset, then release with ADDR_W=4 → busy=1 for exactly 16 cycles, then 0. A read of every word returns INIT_VAL; rd_cnt=16.
- Write 32'hDEADBEEF, we=4'hF, to 32'h1c00_0008; next cycle read the same address → sram_rdata=32'hDEADBEEF one cycle after the read; wr_cnt=1, rd_cnt=1.
- Byte lanes: write we=4'b0100, wdata=32'h00AA_0000 over 32'h11223344 at the same word → read returns 32'h11AA3344.
- Out of range: read 32'h1bff_fffc and 32'h1c00_0000+4*DEPTH → sram_rdata=0, err=1, counters unchanged, memory unchanged.
- Request while busy: sram_en=1 at init cycle 3 → err=1, the request is dropped, and init still finishes at cycle DEPTH.
- Reset mid-init at cycle 5 → outputs return to reset values immediately; after release busy lasts a full DEPTH cycles again. Reads after RUN with no intervening write return the prior sram_rdata value (en=0 hold check).
